instr_fetch: RTL and testbench

- Fetch stage directly upstream of control_unit in the RV32I core.
- Holds the PC and issues in-order word requests to instruction memory over a valid/ready request channel with a valid-only response channel.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Slices each instruction into the opcode/func3/func7 fields that control_unit consumes; handles branch/jump redirects by flushing.

---
 rtl/core_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 77 +++++++
 rtl/instr_fetch.sv | 174 +++++++++++++++++
 tb/tb_instr_fetch.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared definitions for the RV32I core front end.
//                - RV32I major opcode constants consumed by control_unit
//                - Fetch-stage state encoding
//                - Default datapath width
//  Revision    : 1.0  initial release
// ============================================================================
package core_pkg;

    localparam int unsigned CORE_XLEN = 32;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_RUN   = 2'd1,
        FS_DRAIN = 2'd2
    } fetch_state_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : DEPTH x WIDTH synchronous FIFO with flush. The head entry is
//                read straight from registered storage (no write-through).
//                Push and pop in the same cycle are always accepted; count is
//                then unchanged.
//  Ports       : clk, reset_n      clock / async active-low reset
//                i_flush           empty the FIFO (wins over push/pop)
//                i_push, i_push_data  write an entry
//                i_pop             retire the head entry
//                o_head_data       current head entry
//                o_count           number of valid entries (0..DEPTH)
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: nothing reads it unless o_count is non-zero.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;

    a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
        !(i_push && !i_pop && !i_flush && (r_count == CW'(DEPTH))));

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : RV32I fetch stage. Owns the PC, issues in-order word
//                requests to instruction memory, buffers returned words and
//                presents them to decode with opcode/func3/func7 pre-sliced.
//                Redirects flush buffered work and drop in-flight responses.
//  Ports       : clk, reset_n                       clock / async active-low reset
//                imem_req_valid/ready/addr          fetch request channel
//                imem_rsp_valid/data                in-order response channel
//                redirect_valid/pc                  taken branch / jump
//                out_valid/ready, out_instr/pc      decode handshake
//                opcode, func3, func7               fields of out_instr
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch
    import core_pkg::*;
#(
    parameter int             XLEN     = CORE_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int             DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic            func7
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_nxt;
    logic [CW-1:0]     r_drop_cnt;
    logic [CW-1:0]     w_drop_nxt;

    logic [CW-1:0]     w_outstanding;
    logic [CW-1:0]     w_fifo_count;
    logic [CW-1:0]     w_out_after;
    logic [CW:0]       w_credit_used;
    logic              w_req_valid;
    logic              w_accept;
    logic              w_drop_rsp;
    logic              w_push;
    logic              w_pop;
    logic              w_out_valid;
    logic [XLEN-1:0]   w_tag;
    logic [2*XLEN-1:0] w_head;
    logic [XLEN-1:0]   w_out_instr;
    logic              w_unused_redirect_lsb;

    // The address queue's occupancy is the outstanding-request count: every
    // accept pushes one entry and every response (kept or dropped) pops one.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_addr_q (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_flush     (1'b0),
        .i_push      (w_accept),
        .i_push_data (r_pc),
        .i_pop       (imem_rsp_valid),
        .o_head_data (w_tag),
        .o_count     (w_outstanding)
    );

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_instr_q (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_flush     (redirect_valid),
        .i_push      (w_push),
        .i_push_data ({imem_rsp_data, w_tag}),
        .i_pop       (w_pop),
        .o_head_data (w_head),
        .o_count     (w_fifo_count)
    );

    // Credit: in-flight requests plus buffered words never exceed DEPTH, so
    // every response is guaranteed a FIFO slot.
    assign w_credit_used = {1'b0, w_outstanding} + {1'b0, w_fifo_count};
    assign w_req_valid   = (r_state == FS_RUN) && (w_credit_used < (CW+1)'(DEPTH));
    assign w_accept      = w_req_valid && imem_req_ready;
    assign w_drop_rsp    = imem_rsp_valid && (r_drop_cnt != '0);
    // A response landing in the redirect cycle belongs to the old path.
    assign w_push        = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
    assign w_out_valid   = (w_fifo_count != '0);
    assign w_pop         = w_out_valid && out_ready;
    assign w_out_after   = w_outstanding + CW'(w_accept) - CW'(imem_rsp_valid);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_nxt  = r_drop_cnt;

        if (w_drop_rsp) begin
            w_drop_nxt = r_drop_cnt - CW'(1);
        end

        case (r_state)
            FS_BOOT: begin
                w_state_nxt = FS_RUN;
            end
            FS_RUN: begin
                if (w_accept) begin
                    w_pc_nxt = r_pc + XLEN'(4);
                end
            end
            FS_DRAIN: begin
                if (w_drop_nxt == '0) begin
                    w_state_nxt = FS_RUN;
                end
            end
            default: begin
                w_state_nxt = FS_RUN;
            end
        endcase

        // Everything still in flight after this cycle, including a request
        // accepted right now, is on the wrong path and must be discarded.
        if (redirect_valid) begin
            w_pc_nxt    = {redirect_pc[XLEN-1:2], 2'b00};
            w_drop_nxt  = w_out_after;
            w_state_nxt = (w_out_after != '0) ? FS_DRAIN : FS_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= FS_BOOT;
            r_pc       <= RESET_PC;
            r_drop_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_drop_cnt <= w_drop_nxt;
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;

    // Stale storage is masked so decode sees zeros while nothing is valid.
    assign out_valid   = w_out_valid;
    assign w_out_instr = w_out_valid ? w_head[2*XLEN-1:XLEN] : '0;
    assign out_instr   = w_out_instr;
    assign out_pc      = w_out_valid ? w_head[XLEN-1:0] : '0;
    assign opcode      = w_out_instr[6:0];
    assign func3       = w_out_instr[14:12];
    assign func7       = w_out_instr[30];

    assign w_unused_redirect_lsb = &{1'b0, redirect_pc[1:0]};

    a_rsp_has_request : assert property (@(posedge clk) disable iff (!reset_n)
        !(imem_rsp_valid && (w_outstanding == '0)));

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Randomised self-checking bench for instr_fetch. A
//                transaction-level model tracks the expected PC stream, the
//                path ("epoch") each request belongs to and the words that
//                decode should see, and an in-order memory model answers
//                requests with randomised latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_fetch;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    logic            clk;
    logic            reset_n;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic            func7;

    instr_fetch #(
        .XLEN     (XLEN),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .opcode         (opcode),
        .func3          (func3),
        .func7          (func7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Instruction memory contents: ADD at 0x0, SUB at 0x4, hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0033;
        if (a == 32'h4) return 32'h4000_0033;
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    // ---------------- reference model state ----------------
    mreq_t       memq[$];     // requests accepted by memory, in order
    logic [31:0] vis[$];      // PCs decode should see, oldest first
    int          cur_out;     // in-flight requests on the current path
    int          old_out;     // in-flight requests on abandoned paths
    int          epoch;
    int          cyc;
    bit          boot;
    bit          last_redir;
    bit          phase_a;
    logic [31:0] model_pc;
    int          first_ov;
    logic [31:0] first_pc;

    // ---------------- stimulus knobs ----------------
    int p_ready, p_outrdy, p_redir, p_rsp, lat_min, lat_max;

    task automatic set_knobs(input int rdy, input int ordy, input int redir,
                             input int rsp, input int lmin, input int lmax);
        p_ready  = rdy;
        p_outrdy = ordy;
        p_redir  = redir;
        p_rsp    = rsp;
        lat_min  = lmin;
        lat_max  = lmax;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n        = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        #1;
        chk("rst_async_req_valid", imem_req_valid, 0);
        chk("rst_async_out_valid", out_valid, 0);
        repeat (3) @(negedge clk);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_fields", {opcode, func3, func7}, 0);
        memq.delete();
        vis.delete();
        cur_out    = 0;
        old_out    = 0;
        epoch      = 0;
        cyc        = 0;
        boot       = 1'b1;
        last_redir = 1'b0;
        model_pc   = 32'h0;
        first_ov   = -1;
        first_pc   = 32'hFFFF_FFFF;
        reset_n    = 1'b1;
    endtask

    // One cycle, entered at a falling edge: check outputs against the model,
    // choose this cycle's inputs, then advance the model past the next edge.
    task automatic step();
        logic        exp_rv;
        logic        acc;
        logic        pop;
        logic        redir;
        logic        got_new;
        logic [31:0] new_pc;
        logic [31:0] w;
        mreq_t       h;
        int          lat;

        exp_rv = !boot && (old_out == 0) && ((cur_out + vis.size()) < DEPTH);
        chk("req_valid", imem_req_valid, exp_rv);
        if (imem_req_valid) chk("req_addr", imem_req_addr, model_pc);
        chk("out_valid", out_valid, vis.size() != 0);
        if (out_valid && vis.size() != 0) begin
            w = mem_word(vis[0]);
            chk("out_pc", out_pc, vis[0]);
            chk("out_instr", out_instr, w);
            chk("fields", {opcode, func3, func7}, {w[6:0], w[14:12], w[30]});
        end
        if (out_valid && first_ov < 0) begin
            first_ov = cyc;
            first_pc = out_pc;
        end
        if (phase_a && out_valid && out_pc == 32'h0)
            chk("add_fields", {opcode, func3, func7}, {7'b0110011, 3'b000, 1'b0});
        if (phase_a && out_valid && out_pc == 32'h4)
            chk("sub_func7", func7, 1);

        imem_req_ready = ($urandom_range(0, 99) < p_ready);
        out_ready      = ($urandom_range(0, 99) < p_outrdy);
        redir          = !last_redir && ($urandom_range(0, 99) < p_redir);
        redirect_valid = redir;
        if (redir) redirect_pc = ($urandom_range(0, 1) == 1) ? 32'h100 : $urandom;
        else       redirect_pc = $urandom;
        if (memq.size() != 0 && memq[0].due <= cyc && $urandom_range(0, 99) < p_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end

        acc     = imem_req_valid && imem_req_ready;
        pop     = out_valid && out_ready;
        got_new = 1'b0;
        new_pc  = '0;
        if (pop && vis.size() != 0) void'(vis.pop_front());
        if (imem_rsp_valid) begin
            h = memq.pop_front();
            if (h.epoch == epoch) begin
                cur_out--;
                if (!redir) begin
                    got_new = 1'b1;
                    new_pc  = h.addr;
                end
            end else begin
                old_out--;
            end
        end
        if (acc) begin
            lat = $urandom_range(lat_min, lat_max);
            memq.push_back('{addr: imem_req_addr, epoch: epoch, due: cyc + lat});
            cur_out++;
        end
        if (redir) begin
            old_out += cur_out;
            cur_out  = 0;
            epoch++;
            vis.delete();
            model_pc = redirect_pc & ~32'h3;
        end else if (acc) begin
            model_pc = model_pc + 32'h4;
        end
        if (got_new) vis.push_back(new_pc);
        last_redir = redir;
        boot       = 1'b0;
        cyc++;
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            @(negedge clk);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        phase_a        = 1'b0;

        // Streaming: ready memory, 1-cycle latency, decode always ready.
        set_knobs(100, 100, 0, 100, 1, 1);
        do_reset();
        phase_a = 1'b1;
        run_cycles(20);
        phase_a = 1'b0;
        chk("first_out_cycle", first_ov, 3);
        chk("first_out_pc", first_pc, 32'h0);

        // Decode stalled: fetch must stop at DEPTH buffered words.
        set_knobs(100, 0, 0, 100, 1, 1);
        do_reset();
        run_cycles(10);
        chk("stall_req_valid", imem_req_valid, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_head_pc", out_pc, 32'h0);
        set_knobs(100, 100, 0, 100, 1, 1);
        run_cycles(10);

        // Request backpressure with variable latency.
        set_knobs(50, 70, 0, 100, 1, 3);
        run_cycles(300);

        // Redirects against a 4-cycle memory.
        set_knobs(100, 80, 8, 100, 4, 4);
        run_cycles(400);

        // Reset with requests still in flight, then a random mix.
        do_reset();
        set_knobs(60, 60, 4, 70, 1, 6);
        run_cycles(1500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_instr_fetch
`default_nettype wire
